if_id_skid: RTL and testbench
=============================

# if_id_skid

Parametrised, elastic successor to the fixed IF/ID pipeline register. It carries an instruction word and its next-PC from fetch to decode through a two-entry skid buffer with valid/ready handshakes on both sides, so decode can stall fetch without a combinational ready path. A synchronous flush squashes in-flight entries on branch redirect. Widths and the bubble encoding are parameters, so the same block serves other pipeline boundaries.

## Interface

Parameters:
- INST_W, default 32: instruction word width.
- PC_W, default 10: next-PC width.
- NOP_INST, default 0 (INST_W bits): value driven on instOut when no valid entry is held.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; when 0, state clears immediately, independent of clk.
- in_valid  input  1  fetch presents instIn/NPCIn.
- in_ready  output  1  block can accept an entry this cycle.
- instIn  input  INST_W  fetched instruction.
- NPCIn  input  PC_W  next-PC of fetched instruction.
- flush  input  1  synchronous squash of all held entries.
- out_valid  output  1  instOut/NPCOut hold a valid entry.
- out_ready  input  1  decode consumes the head entry this cycle.
- instOut  output  INST_W  head instruction, NOP_INST when out_valid=0.
- NPCOut  output  PC_W  head next-PC, 0 when out_valid=0.
- occ  output  2  entries held: 0, 1 or 2.

## Operation

- push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register (drives outputs directly) and skid register; state EMPTY / ONE / TWO.
- in_ready = (state != TWO); out_valid = (state != EMPTY); occ = 0/1/2 for EMPTY/ONE/TWO. All three are pure decodes of the state register; no dependence on in_valid, out_ready, or flush.
- Transitions (no flush):
  - EMPTY: push -> ONE, main <= input; else stay.
  - ONE: push & pop -> ONE, main <= input; push & !pop -> TWO, skid <= input; !push & pop -> EMPTY, main <= NOP_INST/0; neither -> stay.
  - TWO: pop -> ONE, main <= skid; !pop -> stay. No push possible (in_ready=0).
- Ordering strictly FIFO: skid entry is always younger than main.
- flush=1 at an edge: state -> EMPTY, main and skid <= NOP_INST/0, regardless of push/pop that cycle. A push coinciding with flush is dropped. A pop coinciding with flush is still a completed transfer for decode.
- Reset (reset=0): state EMPTY, main and skid = NOP_INST/0, out_valid=0, occ=0, instOut=NOP_INST, NPCOut=0. in_ready decodes to 1, but no transfer is captured while reset is low. Reset asserted mid-transfer discards all entries.
- Data held in main/skid never changes except by the transitions above. Outputs are stable while out_valid=1 and out_ready=0.

## Timing

- Latency: a push at edge N appears on instOut/NPCOut from after edge N (visible in cycle N+1) when the buffer was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput: 1 entry/cycle sustained when out_ready=1 continuously.
- Backpressure: when out_ready drops, at most one extra entry is accepted (into skid). in_ready falls one cycle after out_ready falls, never combinationally.
- Recovery: from TWO, a pop at edge N gives in_ready=1 in cycle N+1.
- All outputs are registered or pure state decodes. There is no combinational path from any input to any output.
- Reset deassertion is asynchronous. The first capture can occur at the first rising edge with reset=1.

## Test plan

- Reset: hold reset=0 with in_valid=1, instIn=0xDEADBEEF. Required: out_valid=0, occ=0, instOut=0, NPCOut=0 throughout. Release reset, and the first edge captures 0xDEADBEEF/NPC 0x004.
- Streaming: push 0x11111111..0x44444444 with NPC 1..4 on consecutive cycles, out_ready=1. Required: each appears one cycle after its push, in order, occ=1 throughout, in_ready=1.
- Backpressure: stream A, B, C with out_ready=0 from the cycle after A lands. Required: B goes to skid, occ=2, in_ready=0, C is held off by fetch. Raise out_ready to drain A, B, C in order with no loss or duplicate.
- Flush: fill to occ=2, assert flush with in_valid=1, instIn=0x55555555. Required: next cycle occ=0, out_valid=0, instOut=NOP_INST, and 0x55555555 is never output.
- Asynchronous reset mid-stream: with occ=2, pull reset low between edges. Required: out_valid=0 and occ=0 immediately, without waiting for clk.
- Parameter sweep: INST_W=16, PC_W=12, NOP_INST=0x0013. Run the streaming and flush scenarios. Required: the empty output reads 0x0013, and full-width values pass unchanged.

Source files
------------

// File: rtl/if_id_skid_if.sv
// Fetch-to-decode handshake bundle for the if_id_skid elastic pipeline register.
// slave is the buffer's view, master is the fetch/decode environment's view.
interface if_id_skid_if #(
    parameter int unsigned INST_W = 32,
    parameter int unsigned PC_W   = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] instIn;
    logic [PC_W-1:0]   NPCIn;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] instOut;
    logic [PC_W-1:0]   NPCOut;
    logic [1:0]        occ;

    modport slave (
        input  in_valid, instIn, NPCIn, flush, out_ready,
        output in_ready, out_valid, instOut, NPCOut, occ
    );

    modport master (
        output in_valid, instIn, NPCIn, flush, out_ready,
        input  in_ready, out_valid, instOut, NPCOut, occ
    );
endinterface

// File: rtl/if_id_skid.sv
// Two-entry skid buffer between fetch and decode. Handshake outputs decode the
// state register only, so decode backpressure never reaches fetch combinationally.
module if_id_skid #(
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       PC_W     = 10,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic          clk,
    input  logic          reset,
    if_id_skid_if.slave   bus
);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   npc;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam entry_t BUBBLE = {NOP_INST, PC_W'(0)};

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry_c;
    logic   in_ready_c;
    logic   out_valid_c;
    logic   push_c;
    logic   pop_c;

    assign in_entry_c  = {bus.instIn, bus.NPCIn};
    assign in_ready_c  = (state_q != TWO);
    assign out_valid_c = (state_q != EMPTY);
    assign push_c      = bus.in_valid & in_ready_c;
    assign pop_c       = out_valid_c & bus.out_ready;

    // State and storage registers; reset and flush both return to a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state; flush overrides any push/pop in the same cycle.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push_c) begin
                        state_d = ONE;
                        main_d  = in_entry_c;
                    end
                end
                ONE: begin
                    if (push_c && pop_c) begin
                        main_d = in_entry_c;
                    end else if (push_c) begin
                        state_d = TWO;
                        skid_d  = in_entry_c;
                    end else if (pop_c) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                TWO: begin
                    // Skid is always the younger entry, so it promotes to main.
                    if (pop_c) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.occ       = 2'(state_q);
    assign bus.instOut   = main_q.inst;
    assign bus.NPCOut    = main_q.npc;

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid: two parameterisations driven in lockstep and
// compared every cycle against a queue model of a depth-2 FIFO with flush.
module tb_if_id_skid;

    localparam logic [15:0] NOP16 = 16'h0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic [31:0] inst;
    logic [11:0] npc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [11:0] npc;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    if_id_skid_if #(.INST_W(32), .PC_W(10)) bus32 ();
    if_id_skid_if #(.INST_W(16), .PC_W(12)) bus16 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.instIn    = inst;
    assign bus32.NPCIn     = npc[9:0];
    assign bus32.flush     = flush;
    assign bus32.out_ready = out_ready;
    assign bus16.in_valid  = in_valid;
    assign bus16.instIn    = inst[15:0];
    assign bus16.NPCIn     = npc;
    assign bus16.flush     = flush;
    assign bus16.out_ready = out_ready;

    if_id_skid #(.INST_W(32), .PC_W(10)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    if_id_skid #(.INST_W(16), .PC_W(12), .NOP_INST(NOP16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
        end
    endtask

    // Model: a FIFO of at most two entries; the head is what decode sees.
    task automatic compare();
        bit v;
        v = (q.size() > 0);
        chk("in_ready32",  32'(bus32.in_ready),  32'(q.size() < 2));
        chk("out_valid32", 32'(bus32.out_valid), 32'(v));
        chk("occ32",       32'(bus32.occ),       32'(q.size()));
        chk("inst32",      bus32.instOut,        v ? q[0].inst : 32'h0);
        chk("npc32",       32'(bus32.NPCOut),    v ? 32'(q[0].npc[9:0]) : 32'h0);
        chk("in_ready16",  32'(bus16.in_ready),  32'(q.size() < 2));
        chk("out_valid16", 32'(bus16.out_valid), 32'(v));
        chk("occ16",       32'(bus16.occ),       32'(q.size()));
        chk("inst16",      32'(bus16.instOut),   v ? 32'(q[0].inst[15:0]) : 32'(NOP16));
        chk("npc16",       32'(bus16.NPCOut),    v ? 32'(q[0].npc) : 32'h0);
    endtask

    always @(posedge clk) begin
        bit push;
        bit pop;
        if (reset) begin
            push = in_valid && (q.size() < 2);
            pop  = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{inst: inst, npc: npc});
            end
        end
        #1;
        compare();
    end

    always @(negedge reset) q.delete();

    task automatic drive(input bit v, input logic [31:0] i, input logic [11:0] n,
                         input bit ordy, input bit fl);
        @(negedge clk);
        in_valid  = v;
        inst      = i;
        npc       = n;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        in_valid  = 1'b1;
        inst      = 32'hDEADBEEF;
        npc       = 12'h004;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset held with fetch presenting data: nothing captured.
        for (int k = 0; k < 3; k++) begin
            after_edge();
            chk("rst_out_valid", 32'(bus32.out_valid), 32'h0);
            chk("rst_occ",       32'(bus32.occ),       32'h0);
            chk("rst_inst",      bus32.instOut,        32'h0);
            chk("rst_npc",       32'(bus32.NPCOut),    32'h0);
            chk("rst_inst16",    32'(bus16.instOut),   32'h0013);
        end
        @(negedge clk);
        reset = 1'b1;
        after_edge();
        chk("first_inst", bus32.instOut,      32'hDEADBEEF);
        chk("first_npc",  32'(bus32.NPCOut),  32'h004);
        chk("first_occ",  32'(bus32.occ),     32'h1);

        // Streaming with decode always ready.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 32'h11111111 * 32'(k), 12'(k), 1'b1, 1'b0);
            after_edge();
            chk("stream_inst",  bus32.instOut,       32'h11111111 * 32'(k));
            chk("stream_npc",   32'(bus32.NPCOut),   32'(k));
            chk("stream_occ",   32'(bus32.occ),      32'h1);
            chk("stream_ready", 32'(bus32.in_ready), 32'h1);
        end
        drive(1'b0, 32'h0, 12'h0, 1'b1, 1'b0);
        after_edge();
        chk("drained_valid", 32'(bus32.out_valid), 32'h0);

        // Backpressure: A lands, B skids, C held off by fetch.
        drive(1'b1, 32'hAAAA0001, 12'h0A1, 1'b0, 1'b0);
        after_edge();
        chk("bp_a_inst", bus32.instOut, 32'hAAAA0001);
        drive(1'b1, 32'hBBBB0002, 12'h0B2, 1'b0, 1'b0);
        after_edge();
        chk("bp_occ2",   32'(bus32.occ),      32'h2);
        chk("bp_rdy0",   32'(bus32.in_ready), 32'h0);
        chk("bp_head_a", bus32.instOut,       32'hAAAA0001);
        drive(1'b1, 32'hCCCC0003, 12'h0C3, 1'b0, 1'b0);
        after_edge();
        chk("bp_hold_a", bus32.instOut,       32'hAAAA0001);
        drive(1'b1, 32'hCCCC0003, 12'h0C3, 1'b1, 1'b0);
        after_edge();
        chk("bp_head_b", bus32.instOut,       32'hBBBB0002);
        chk("bp_occ1",   32'(bus32.occ),      32'h1);
        drive(1'b1, 32'hCCCC0003, 12'h0C3, 1'b1, 1'b0);
        after_edge();
        chk("bp_head_c", bus32.instOut,       32'hCCCC0003);
        drive(1'b0, 32'h0, 12'h0, 1'b1, 1'b0);
        after_edge();
        chk("bp_empty",  32'(bus32.occ),      32'h0);

        // Flush from full with a coincident push.
        drive(1'b1, 32'h12340001, 12'h001, 1'b0, 1'b0);
        drive(1'b1, 32'h12340002, 12'h002, 1'b0, 1'b0);
        after_edge();
        chk("fl_full", 32'(bus32.occ), 32'h2);
        drive(1'b1, 32'h55555555, 12'h555, 1'b0, 1'b1);
        after_edge();
        chk("fl_occ",    32'(bus32.occ),       32'h0);
        chk("fl_valid",  32'(bus32.out_valid), 32'h0);
        chk("fl_inst",   bus32.instOut,        32'h0);
        chk("fl_inst16", 32'(bus16.instOut),   32'h0013);
        drive(1'b0, 32'h0, 12'h0, 1'b1, 1'b0);
        after_edge();
        chk("fl_stays_empty", 32'(bus32.occ), 32'h0);

        // Full-width values through the narrow instance.
        drive(1'b1, 32'hFFFFFFFF, 12'hFFF, 1'b1, 1'b0);
        after_edge();
        chk("fw_inst16", 32'(bus16.instOut), 32'h0000FFFF);
        chk("fw_npc16",  32'(bus16.NPCOut),  32'h00000FFF);
        chk("fw_npc32",  32'(bus32.NPCOut),  32'h000003FF);

        // Asynchronous reset between edges while full.
        drive(1'b1, 32'h0BAD0001, 12'h011, 1'b0, 1'b0);
        drive(1'b1, 32'h0BAD0002, 12'h022, 1'b0, 1'b0);
        after_edge();
        chk("ar_full", 32'(bus32.occ), 32'h2);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid32", 32'(bus32.out_valid), 32'h0);
        chk("ar_occ32",   32'(bus32.occ),       32'h0);
        chk("ar_valid16", 32'(bus16.out_valid), 32'h0);
        chk("ar_inst16",  32'(bus16.instOut),   32'h0013);
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic with phases of heavy backpressure.
        for (int k = 0; k < 3000; k++) begin
            bit ordy;
            if ((k / 200) % 2 == 1) ordy = ($urandom_range(0, 3) == 0);
            else                    ordy = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, $urandom, 12'($urandom),
                  ordy, $urandom_range(0, 15) == 0);
        end
        drive(1'b0, 32'h0, 12'h0, 1'b1, 1'b0);
        after_edge();
        after_edge();
        chk("final_empty", 32'(bus32.occ), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
